eth_rx_deframer: RTL

ETH_RX_DEFRAMER -- requirements
Module: eth_rx_deframer

---
 rtl/eth_pkg.sv | 17 +
 rtl/eth_crc32_byte.sv | 20 ++
 rtl/eth_rx_deframer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Shared state encoding and framing/CRC constants for the Ethernet receive path
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } eth_state_t;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_byte.sv
// rtl/eth_crc32_byte.sv - Combinational reflected CRC-32 update for one byte, LSB first
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_rx_deframer.sv
// rtl/eth_rx_deframer.sv - Strips preamble/SFD/FCS from wire bytes and reports per-frame length status
// ETH_RX_FCS_CHECK_EN adds the CRC-32 FCS check and the 4-byte delay line that hides the FCS.
module eth_rx_deframer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_rxen,
    input  logic [7:0]  in_rxd,
    output logic        out_dll_rxen,
    output logic [7:0]  out_dll_rxd,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_frame_ok,
    output logic [10:0] out_len
);
    import eth_pkg::*;

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    eth_state_t  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        dll_rxen_q, dll_rxen_d;
    logic [7:0]  dll_rxd_q, dll_rxd_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        ok_q, ok_d;
    logic [10:0] len_q, len_d;
    logic        len_ok;

`ifdef ETH_RX_FCS_CHECK_EN
    logic [3:0][7:0] dl_q, dl_d;
    logic [31:0]     crc_q, crc_d, crc_next;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (in_rxd),
        .crc_out (crc_next)
    );
`endif

    // Saturation keeps cnt_q at MAX_LEN, so ovf_q carries the "too long" fact.
    assign len_ok = !ovf_q && (cnt_q >= MIN_L) && (cnt_q >= 11'd4) && (cnt_q <= MAX_L);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        dll_rxen_d = 1'b0;
        dll_rxd_d  = dll_rxd_q;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        ok_d       = ok_q;
        len_d      = len_q;
`ifdef ETH_RX_FCS_CHECK_EN
        dl_d       = dl_q;
        crc_d      = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_rxen) state_d = (in_rxd == ETH_PREAMBLE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!in_rxen) begin
                    state_d = IDLE;
                end else if (in_rxd == ETH_SFD) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef ETH_RX_FCS_CHECK_EN
                    dl_d    = '0;
                    crc_d   = ETH_CRC_INIT;
`endif
                end else if (in_rxd != ETH_PREAMBLE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (in_rxen) begin
                    if (cnt_q == MAX_L) ovf_d = 1'b1;
                    else                cnt_d = cnt_q + 11'd1;
`ifdef ETH_RX_FCS_CHECK_EN
                    crc_d = crc_next;
                    dl_d  = {dl_q[2:0], in_rxd};
                    if (cnt_q >= 11'd4 && !ovf_d) begin
                        dll_rxen_d = 1'b1;
                        dll_rxd_d  = dl_q[3];
                        sof_d      = (cnt_q == 11'd4);
                    end
`else
                    if (!ovf_d) begin
                        dll_rxen_d = 1'b1;
                        dll_rxd_d  = in_rxd;
                        sof_d      = (cnt_q == 11'd0);
                    end
`endif
                end else begin
                    state_d = IDLE;
                    eof_d   = 1'b1;
                    len_d   = cnt_q;
`ifdef ETH_RX_FCS_CHECK_EN
                    ok_d    = len_ok && (crc_q == ETH_CRC_RESIDUE);
`else
                    ok_d    = len_ok;
`endif
                end
            end
            DROP: begin
                if (!in_rxen) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            dll_rxen_q <= 1'b0;
            dll_rxd_q  <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            ok_q       <= 1'b0;
            len_q      <= '0;
`ifdef ETH_RX_FCS_CHECK_EN
            dl_q       <= '0;
            crc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            dll_rxen_q <= dll_rxen_d;
            dll_rxd_q  <= dll_rxd_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            ok_q       <= ok_d;
            len_q      <= len_d;
`ifdef ETH_RX_FCS_CHECK_EN
            dl_q       <= dl_d;
            crc_q      <= crc_d;
`endif
        end
    end

    assign out_dll_rxen = dll_rxen_q;
    assign out_dll_rxd  = dll_rxd_q;
    assign out_sof      = sof_q;
    assign out_eof      = eof_q;
    assign out_frame_ok = ok_q;
    assign out_len      = len_q;

endmodule
